// File: rtl/processor_arm_mc.sv
// processor_arm_mc: multicycle 64-bit LEGv8-subset processor core.
//
// Each instruction walks FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK).
// The core supports these instructions:
//   ADD, SUB, AND, ORR  - R-type register/register ALU operations
//   LDUR, STUR          - load/store at base register + signed 9-bit offset
//   CBZ                 - PC-relative branch when a register is zero
// Any other encoding is executed as a NOP.
//
// Data memory handshake: the enable stays high with a stable address and
// data until the memory raises DM_ready on a rising edge. A memory that
// answers in the first MEM cycle adds no wait states.
//
// Parameters:
//   N         datapath, register and address width in bits
//   RESET_PC  PC value loaded on reset
//
// Ports:
//   CLOCK_50        sole clock, rising-edge active
//   reset           asynchronous, active-high reset
//   IM_addr         instruction fetch byte address (current PC)
//   IM_readData     instruction word, combinational from IM_addr
//   DM_addr         data memory byte address
//   DM_writeData    store data
//   DM_writeEnable  store request (high only in MEM)
//   DM_readEnable   load request (high only in MEM)
//   DM_readData     load data, valid when DM_ready is high
//   DM_ready        memory completes the pending request on this edge
//
// Optional build macro PROCESSOR_ARM_MC_PERF_EN adds two 64-bit counters:
//   instret    instructions retired (including NOPs)
//   stall_cnt  MEM cycles spent waiting on DM_ready
module processor_arm_mc #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    output logic [N-1:0]  IM_addr,
    input  logic [31:0]   IM_readData,
    output logic [N-1:0]  DM_addr,
    output logic [N-1:0]  DM_writeData,
    output logic          DM_writeEnable,
    output logic          DM_readEnable,
    input  logic [N-1:0]  DM_readData,
    input  logic          DM_ready
`ifdef PROCESSOR_ARM_MC_PERF_EN
    ,
    output logic [63:0]   instret,
    output logic [63:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK
    } state_t;

    state_t        state;
    logic [N-1:0]  pc;
    logic [N-1:0]  instr_pc;
    logic [31:0]   ir;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  result_reg;
    logic [N-1:0]  mem_addr;
    logic          dm_re;
    logic          dm_we;
    logic [N-1:0]  regs [0:31];

    // Instruction decode, taken from the latched instruction word.
    logic          is_add, is_sub, is_and, is_orr;
    logic          is_ldur, is_stur, is_cbz, is_rtype;
    logic [4:0]    b_idx;
    logic [N-1:0]  alu_res;
    logic [N-1:0]  mem_offset;
    logic [N-1:0]  branch_offset;

    // Bits 11:10 (shamt low bits / op2) carry no meaning for this subset.
    logic          unused_ir_bits;

    assign unused_ir_bits = ^ir[11:10];

    assign is_add   = (ir[31:21] == 11'b10001011000);
    assign is_sub   = (ir[31:21] == 11'b11001011000);
    assign is_and   = (ir[31:21] == 11'b10001010000);
    assign is_orr   = (ir[31:21] == 11'b10101010000);
    assign is_ldur  = (ir[31:21] == 11'b11111000010);
    assign is_stur  = (ir[31:21] == 11'b11111000000);
    assign is_cbz   = (ir[31:24] == 8'b10110100);
    assign is_rtype = is_add | is_sub | is_and | is_orr;

    // STUR and CBZ keep their second source in the Rt field; R-type uses Rm.
    assign b_idx = (is_stur || is_cbz) ? ir[4:0] : ir[20:16];

    assign mem_offset    = {{(N-9){ir[20]}}, ir[20:12]};
    assign branch_offset = {{(N-21){ir[23]}}, ir[23:5], 2'b00};

    // Unrecognised opcodes fall through to zero; they never reach WRITEBACK.
    always_comb begin
        alu_res = '0;
        if (is_add)      alu_res = a_reg + b_reg;
        else if (is_sub) alu_res = a_reg - b_reg;
        else if (is_and) alu_res = a_reg & b_reg;
        else if (is_orr) alu_res = a_reg | b_reg;
    end

    // X31 is the zero register: it reads as 0 and its storage is never written.
    function automatic logic [N-1:0] read_reg(input logic [4:0] idx);
        read_reg = (idx == 5'd31) ? '0 : regs[idx];
    endfunction

    assign IM_addr        = pc;
    assign DM_addr        = mem_addr;
    assign DM_writeData   = b_reg;
    assign DM_readEnable  = dm_re;
    assign DM_writeEnable = dm_we;

    // Main control FSM. The memory enables are registered: they rise on
    // entry to MEM and drop on the completing edge. Because reset is
    // asynchronous, a reset during a MEM stall clears them at once and
    // aborts the request before any register write can happen.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr_pc   <= RESET_PC;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            mem_addr   <= '0;
            dm_re      <= 1'b0;
            dm_we      <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir       <= IM_readData;
                    instr_pc <= pc;
                    pc       <= pc + N'(4);
                    state    <= DECODE;
                end
                DECODE: begin
                    a_reg <= read_reg(ir[9:5]);
                    b_reg <= read_reg(b_idx);
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (is_rtype) begin
                        result_reg <= alu_res;
                        state      <= WRITEBACK;
                    end else if (is_ldur || is_stur) begin
                        mem_addr <= a_reg + mem_offset;
                        dm_re    <= is_ldur;
                        dm_we    <= is_stur;
                        state    <= MEM;
                    end else begin
                        // CBZ or NOP. A not-taken CBZ keeps the PC+4
                        // already computed in FETCH.
                        if (is_cbz && (b_reg == '0)) begin
                            pc <= instr_pc + branch_offset;
                        end
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (DM_ready) begin
                        dm_re <= 1'b0;
                        dm_we <= 1'b0;
                        if (is_ldur) begin
                            result_reg <= DM_readData;
                            state      <= WRITEBACK;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    if (ir[4:0] != 5'd31) begin
                        regs[ir[4:0]] <= result_reg;
                    end
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef PROCESSOR_ARM_MC_PERF_EN
    logic retire;

    // An instruction retires on the edge that sends the FSM back to FETCH.
    assign retire = ((state == EXECUTE) && !is_rtype && !is_ldur && !is_stur) ||
                    ((state == MEM) && DM_ready && !is_ldur) ||
                    (state == WRITEBACK);

    // Free-running counters; both wrap naturally at 2^64.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (retire) begin
                instret <= instret + 64'd1;
            end
            if ((state == MEM) && !DM_ready) begin
                stall_cnt <= stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: doc/processor_arm_mc.md
PROCESSOR_ARM_MC -- requirements
Module: processor_arm_mc

Interface
REQ-001 SHALL have parameter N, default 64, meaning datapath, register and address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IM_addr  output  N  instruction fetch byte address.
REQ-006 IM_readData  input  32  instruction word, combinational from IM_addr.
REQ-007 DM_addr  output  N  data memory byte address.
REQ-008 DM_writeData  output  N  store data.
REQ-009 DM_writeEnable  output  1  store request.
REQ-010 DM_readEnable  output  1  load request.
REQ-011 DM_readData  input  N  load data, valid when DM_ready=1.
REQ-012 DM_ready  input  1  memory completes the pending request on this edge.

Function
REQ-013 SHALL implement a multicycle FSM: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
REQ-014 FETCH: IM_addr=PC; latch IR and instr_pc=PC; PC<=PC+4; always ->DECODE.
REQ-015 DECODE: read Rn=IR[9:5], Rm/Rt (R-type IR[20:16], STUR/CBZ IR[4:0]) into A/B registers; ->EXECUTE.
REQ-016 Supported opcodes IR[31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ IR[31:24]=10110100.
REQ-017 EXECUTE: R-type ALU result ->WRITEBACK; LDUR/STUR address = A + sign-extend(IR[20:12]) ->MEM; CBZ ->FETCH.
REQ-018 CBZ: if B==0, PC<=instr_pc + (sign-extend(IR[23:5])<<2) in EXECUTE; else PC keeps PC+4.
REQ-019 Any other opcode SHALL be a NOP: EXECUTE ->FETCH, no register or memory side effect.
REQ-020 MEM: DM_readEnable (LDUR) or DM_writeEnable (STUR) held 1 with stable DM_addr/DM_writeData until a rising edge with DM_ready=1.
REQ-021 DM_ready=1 in the first MEM cycle gives zero wait states; each cycle DM_ready=0 adds one stall cycle.
REQ-022 On completion LDUR captures DM_readData ->WRITEBACK; STUR ->FETCH.
REQ-023 Enables SHALL be 0 in every state except MEM; DM_ready is ignored outside MEM.
REQ-024 WRITEBACK writes Rd=IR[4:0] with ALU result or load data; ->FETCH.
REQ-025 Register file: 32 x N; X31 reads 0; writes to X31 discarded.
REQ-026 CPI (zero wait): R-type 4, LDUR 5, STUR 4, CBZ 3, NOP 3.
REQ-027 All arithmetic SHALL be N-bit modulo; PC wraps at 2^N.

Reset
REQ-028 reset=1 SHALL immediately force state FETCH, PC=RESET_PC, IR=0, X0..X30=0.
REQ-029 During reset DM_writeEnable=0, DM_readEnable=0, DM_addr=0, DM_writeData=0, IM_addr=RESET_PC.
REQ-030 reset asserted mid-MEM SHALL abort the request; no register write occurs.

Configuration
REQ-031 Macro PROCESSOR_ARM_MC_PERF_EN defined: output instret (64-bit) counts instructions reaching FETCH from EXECUTE/MEM/WRITEBACK (incl. NOP), and output stall_cnt (64-bit) counts MEM cycles with DM_ready=0; both reset to 0 and wrap.
REQ-032 Macro undefined: neither port nor counters exist; all other behaviour identical.

Verification
REQ-033 X1=5, X2=7; ADD X3,X1,X2 -> X3=12 after 4 cycles; next IM_addr=PC+4.
REQ-034 STUR X3,[X0,#8] with DM_ready low 3 cycles -> DM_writeEnable high 4 cycles, DM_addr=8, DM_writeData=12, then FETCH.
REQ-035 LDUR X4,[X0,#-8] with X0=16, zero wait -> DM_addr=8, X4=DM_readData, 5 cycles.
REQ-036 CBZ X31,#-2 at PC=0x40 -> next IM_addr=0x38; CBZ X3 (=12) -> next IM_addr=0x44.
REQ-037 reset pulsed during MEM stall of LDUR X5 -> enables drop to 0 same cycle, X5 unchanged(0), IM_addr=RESET_PC.
REQ-038 ADD X31,X1,X2 then ORR X6,X31,X31 -> X6=0; opcode 0xFFFFFFFF -> NOP, 3 cycles.
